// File: rtl/pulse_sync_fast_to_slow.sv
// Fast-to-slow pulse crossing via toggle req/ack; pulse_out lands SYNC_STAGES+1(+1) slow edges after launch.
// No backpressure: events arriving mid-transfer are queued in a saturating counter, excess sets overflow.
`timescale 1ns/1ps
module pulse_sync_fast_to_slow #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic             clk_slow,
  input  logic             pulse_in,
  input  logic             clr_overflow,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             pulse_out
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("pulse_sync_fast_to_slow: SYNC_STAGES must be >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pulse_sync_fast_to_slow: CNT_W must be >= 1");
  end

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------- clk_fast domain ----------------
  state_e                 state_q, state_d;
  logic                   req_tgl_q, req_tgl_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic                   launch;
  logic                   ack_seen;
  logic                   drop;

  // ---------------- clk_slow domain ----------------
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   req_edge_q;
  logic                   pulse_out_q, pulse_out_d;
  logic                   ack_tgl;

  assign launch   = (state_q == IDLE) && (pulse_in || (pending_q != '0));
  assign ack_seen = (ack_sync_q[SYNC_STAGES-1] == req_tgl_q);

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (launch)   state_d = WAIT_ACK;
      WAIT_ACK: if (ack_seen) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == WAIT_ACK);
  end

  // A backlog launch with a fresh pulse_in in the same cycle nets out to no change.
  always_comb begin
    req_tgl_d = req_tgl_q ^ launch;
    pending_d = pending_q;
    drop      = 1'b0;
    if (state_q == IDLE) begin
      if ((pending_q != '0) && !pulse_in) begin
        pending_d = pending_q - CNT_ONE;
      end
    end else if (pulse_in) begin
      if (pending_q != CNT_MAX) begin
        pending_d = pending_q + CNT_ONE;
      end else begin
        drop = 1'b1;
      end
    end
    overflow_d = drop | (overflow_q & ~clr_overflow);
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      req_tgl_q  <= 1'b0;
      ack_sync_q <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      req_tgl_q  <= req_tgl_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl};
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;

  // The registered edge detector doubles as the acknowledge toggle.
  assign ack_tgl     = req_edge_q;
  assign pulse_out_d = req_sync_q[SYNC_STAGES-1] ^ req_edge_q;

  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q  <= '0;
      req_edge_q  <= 1'b0;
      pulse_out_q <= 1'b0;
    end else begin
      req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
      req_edge_q  <= req_sync_q[SYNC_STAGES-1];
      pulse_out_q <= pulse_out_d;
    end
  end

  assign pulse_out = pulse_out_q;

`ifndef SYNTHESIS
  a_no_wrap_at_max : assert property (@(posedge clk_fast) disable iff (!rst_n)
    (state_q == WAIT_ACK && pending_q == CNT_MAX) |=> (pending_q == CNT_MAX));
  a_single_cycle_out : assert property (@(posedge clk_slow) disable iff (!rst_n)
    pulse_out_q |=> !pulse_out_q);
`endif

endmodule
